// File: rtl/dec_count_sched.sv
// rtl/dec_count_sched.sv - timer-slot scheduler: allocates 4-bit down-counters, decrements on tick,
// reports expired slots one at a time over a valid/ready port with round-robin arbitration.
module dec_count_sched #(
  parameter int NSLOT = 8,
  parameter int CW    = 4,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic             req_valid,
  input  logic [CW-1:0]    req_cnt,
  output logic             req_ready,
  output logic [SW-1:0]    req_slot,
  output logic             exp_valid,
  output logic [SW-1:0]    exp_slot,
  input  logic             exp_ready,
  output logic [NSLOT-1:0] busy,
  output logic [SW:0]      active_cnt
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count     [NSLOT];
  logic [CW-1:0]    w_count_nxt [NSLOT];
  logic [NSLOT-1:0] r_pending, w_pending_nxt, w_busy;
  logic [SW-1:0]    r_exp_slot, r_rr_ptr, w_free_slot, w_pick;
  logic [SW:0]      w_active;
  logic             w_load, w_hshk, w_found;
  int               w_idx;

  // Lowest free slot wins allocation; everything here derives from registered state only.
  always_comb begin
    w_busy      = '0;
    w_free_slot = '0;
    w_active    = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      w_busy[i] = (r_count[i] != '0) | r_pending[i];
      if (!w_busy[i]) w_free_slot = SW'(i);
      w_active = w_active + (SW+1)'(w_busy[i]);
    end
  end

  // Round-robin pick: first pending slot strictly after the last one served.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NSLOT; k++) begin
      w_idx = (int'(r_rr_ptr) + 1 + k) % NSLOT;
      if (!w_found && r_pending[w_idx]) begin
        w_pick  = SW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  assign req_ready  = en & ~(&w_busy);
  assign req_slot   = w_free_slot;
  assign busy       = w_busy;
  assign active_cnt = w_active;
  assign exp_valid  = en & (r_state == S_OFFER);
  assign exp_slot   = r_exp_slot;
  assign w_load     = req_valid & req_ready;
  assign w_hshk     = exp_valid & exp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|r_pending) w_state_nxt = S_OFFER;
      S_OFFER: if (exp_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!en) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < NSLOT; i++) begin
      w_count_nxt[i] = r_count[i];
      if (w_load && (w_free_slot == SW'(i))) begin
        if (req_cnt == '0) w_pending_nxt[i] = 1'b1;
        else               w_count_nxt[i]   = req_cnt;
      end else if (tick && (r_count[i] != '0)) begin
        w_count_nxt[i] = r_count[i] - CW'(1);
        if (r_count[i] == CW'(1)) w_pending_nxt[i] = 1'b1;
      end
    end
    if (w_hshk) w_pending_nxt[r_exp_slot] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) r_count[i] <= '0;
      r_pending  <= '0;
      r_exp_slot <= '0;
      r_rr_ptr   <= SW'(NSLOT - 1);
    end else if (!en) begin
      for (int i = 0; i < NSLOT; i++) r_count[i] <= '0;
      r_pending  <= '0;
      r_exp_slot <= '0;
      r_rr_ptr   <= SW'(NSLOT - 1);
    end else begin
      for (int i = 0; i < NSLOT; i++) r_count[i] <= w_count_nxt[i];
      r_pending <= w_pending_nxt;
      if ((r_state == S_IDLE) && (|r_pending)) r_exp_slot <= w_pick;
      if (w_hshk) r_rr_ptr <= r_exp_slot;
    end
  end

endmodule
